// File: rtl/wen_dec_pkg.sv
// Shared definitions for the write-enable decoder pipeline.
// Holds the default parameter values and the one-hot decode helper used by
// the RTL decode stage.
package wen_dec_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned STAGES_DEF = 1;

  // Widest index the decode helper supports; narrower users cast down.
  localparam int unsigned MAX_ADDR_W = 8;
  localparam int unsigned MAX_OUT_W  = 1 << MAX_ADDR_W;

  // One-hot decode of addr, all-zero when en is low.
  function automatic logic [MAX_OUT_W-1:0] onehot_dec(input logic [MAX_ADDR_W-1:0] addr,
                                                      input logic                  en);
    logic [MAX_OUT_W-1:0] vec;
    vec = '0;
    if (en) vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/wen_dec_slice.sv
// One valid/ready register slice of the decoder pipeline.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load           slice takes the upstream beat (or bubble) this cycle
//   up_valid       upstream beat valid
//   up_data        upstream payload {en, addr}
//   dn_valid       stored beat valid (registered)
//   dn_data        stored payload (registered)
// The ready chain lives in the top so the whole chain resolves in one block.
module wen_dec_slice #(
  parameter int unsigned W = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  output logic [W-1:0] dn_data
);

  // Loading a bubble clears the valid bit; loading a beat replaces contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (load) begin
      dn_valid <= up_valid;
      dn_data  <= up_data;
    end
  end

endmodule

// File: rtl/wen_decoder_pipe.sv
// Register-file write-enable decoder with a STAGES-deep valid/ready pipeline.
// An ADDR_W-bit index becomes a 2**ADDR_W one-hot enable, gated by en_i.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   valid_i, ready_o   upstream handshake (ready_o is combinational)
//   addr_i, en_i       register index and write enable of the request
//   valid_o, ready_i   downstream handshake
//   data_o             one-hot (or zero) write-enable vector, decoded from the last slice
// Build option: define WEN_DEC_X0_MASK_EN to force data_o to zero for index 0
// (x0 hardwired to zero); the beat is still emitted.
module wen_decoder_pipe
  import wen_dec_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   en_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [(1<<ADDR_W)-1:0] data_o
);

  localparam int unsigned OUT_W = 1 << ADDR_W;
  localparam int unsigned PW    = ADDR_W + 1;

  // Index 0 is the pipeline input; index k+1 is the output of slice k.
  logic [STAGES:0] cv;
  logic [PW-1:0]   cd [STAGES+1];
  logic [STAGES:0] rdy_c;

  logic              last_en;
  logic [ADDR_W-1:0] last_addr;

  assign cv[0] = valid_i;
  assign cd[0] = {en_i, addr_i};

  // Ready chain: a slice can load when empty or when its successor can load.
  always_comb begin
    rdy_c         = '0;
    rdy_c[STAGES] = ready_i;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy_c[k] = ~cv[k+1] | rdy_c[k+1];
    end
  end

  assign ready_o = rdy_c[0];

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
    wen_dec_slice #(.W(PW)) u_slice (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (rdy_c[k]),
      .up_valid (cv[k]),
      .up_data  (cd[k]),
      .dn_valid (cv[k+1]),
      .dn_data  (cd[k+1])
    );
  end

  assign valid_o              = cv[STAGES];
  assign {last_en, last_addr} = cd[STAGES];

  // Decode straight from the last slice so a stalled beat stays stable.
  always_comb begin
    data_o = OUT_W'(onehot_dec(MAX_ADDR_W'(last_addr), last_en & valid_o));
`ifdef WEN_DEC_X0_MASK_EN
    if (last_addr == '0) data_o = '0;
`endif
  end

`ifndef SYNTHESIS
  // Upstream must hold valid_i and its payload stable while stalled.
  logic          stall_q;
  logic [PW-1:0] held_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= 1'b0;
    else       stall_q <= valid_i & ~ready_o;
    held_q <= cd[0];
  end

  always @(posedge clk_i) begin
    if (!rst_i && stall_q) assert (valid_i && (cd[0] == held_q));
  end
`endif

endmodule

// File: tb/tb_wen_decoder_pipe.sv
// Self-checking bench for wen_decoder_pipe.
// Three instances: id0 ADDR_W=5/STAGES=1, id1 ADDR_W=5/STAGES=2, id2 ADDR_W=3/STAGES=2.
// A queue model (beats with pipeline positions) is compared every cycle;
// directed literal checks pin the model. Honours WEN_DEC_X0_MASK_EN.
module tb_wen_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [2:0] valid_i, ready_i, en_i;
  logic [2:0] ready_o, valid_o;
  logic [4:0] addr_i [3];
  logic [31:0] data0, data1;
  logic [7:0]  data2;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wen_decoder_pipe #(.ADDR_W(5), .STAGES(1)) u_id0 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .addr_i(addr_i[0]), .en_i(en_i[0]), .valid_o(valid_o[0]), .ready_i(ready_i[0]),
    .data_o(data0));

  wen_decoder_pipe #(.ADDR_W(5), .STAGES(2)) u_id1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .addr_i(addr_i[1]), .en_i(en_i[1]), .valid_o(valid_o[1]), .ready_i(ready_i[1]),
    .data_o(data1));

  wen_decoder_pipe #(.ADDR_W(3), .STAGES(2)) u_id2 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i[2]), .ready_o(ready_o[2]),
    .addr_i(addr_i[2][2:0]), .en_i(en_i[2]), .valid_o(valid_o[2]), .ready_i(ready_i[2]),
    .data_o(data2));

  localparam int S_OF [3] = '{1, 2, 2};

  typedef struct {
    int unsigned addr;
    bit          en;
    int          pos;
  } beat_t;

  beat_t q [3][$];
  beat_t nq[$];
  beat_t nb;
  int    ahead, np;
  bit    ev, er;
  logic [31:0] ed;

  function automatic logic [31:0] get_data(input int id);
    case (id)
      0:       return data0;
      1:       return data1;
      default: return {24'h0, data2};
    endcase
  endfunction

  // Expected enable vector for a beat.
  function automatic logic [31:0] model_dec(input int unsigned addr, input bit en);
    if (!en) return 32'h0;
`ifdef WEN_DEC_X0_MASK_EN
    if (addr == 0) return 32'h0;
`endif
    return 32'h1 << addr;
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s id=%0d got=%h want=%h t=%0t", nm, id, got, want, $time);
    end
  endtask

  // Model: beats ordered oldest first; a beat advances one position unless
  // the position ahead is still occupied after the beat in front has moved.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int id = 0; id < 3; id++) begin
        ev = (q[id].size() > 0) && (q[id][0].pos == S_OF[id] - 1);
        ed = ev ? model_dec(q[id][0].addr, q[id][0].en) : 32'h0;
        nq.delete();
        ahead = S_OF[id];
        for (int i = 0; i < q[id].size(); i++) begin
          if (i == 0 && q[id][i].pos == S_OF[id] - 1 && ready_i[id]) continue;
          np = q[id][i].pos + 1;
          if (np >= ahead) np = ahead - 1;
          nb = q[id][i];
          nb.pos = np;
          nq.push_back(nb);
          ahead = np;
        end
        er = (ahead > 0);
        check("valid_o", id, {31'h0, valid_o[id]}, {31'h0, ev});
        check("ready_o", id, {31'h0, ready_o[id]}, {31'h0, er});
        check("data_o", id, get_data(id), ed);
        if (rst_i) begin
          q[id].delete();
        end else begin
          if (valid_i[id] && er) begin
            nb.addr = 32'(addr_i[id]);
            nb.en   = en_i[id];
            nb.pos  = 0;
            nq.push_back(nb);
          end
          q[id] = nq;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send(input int id, input int unsigned a, input bit e);
    bit done;
    done = 1'b0;
    valid_i[id] = 1'b1;
    addr_i[id]  = 5'(a);
    en_i[id]    = e;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      done = ready_o[id];
      tick();
    end
    if (!done) begin
      checks++;
      errs++;
      $display("FAIL send_timeout id=%0d got=stalled want=accepted", id);
    end
  endtask

  logic [31:0] x0_exp;

  initial begin
`ifdef WEN_DEC_X0_MASK_EN
    x0_exp = 32'h0;
`else
    x0_exp = 32'h1;
`endif
    rst_i   = 1'b1;
    valid_i = 3'b111;
    ready_i = 3'b111;
    en_i    = 3'b111;
    for (int i = 0; i < 3; i++) addr_i[i] = 5'd0;

    // Reset held two cycles with valid_i asserted.
    tick();
    chk_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", i, {31'h0, valid_o[i]}, 32'h0);
      check("rst_data", i, get_data(i), 32'h0);
    end
    rst_i   = 1'b0;
    valid_i = 3'b000;
    tick();
    tick();
    check("post_rst_valid", 0, {29'h0, valid_o}, 32'h0);

    // Back-to-back sweep on the single-stage instance.
    for (int a = 0; a < 32; a++) begin
      send(0, a, 1'b1);
      check("sweep_valid", 0, {31'h0, valid_o[0]}, 32'h1);
      check("sweep_data", 0, data0, (a == 0) ? x0_exp : (32'h1 << a));
    end
    valid_i[0] = 1'b0;
    tick();

    // Enable gate: beat still emitted with zero decode.
    send(0, 7, 1'b0);
    valid_i[0] = 1'b0;
    check("engate_valid", 0, {31'h0, valid_o[0]}, 32'h1);
    check("engate_data", 0, data0, 32'h0);
    tick();

    // Backpressure on the two-stage instance.
    ready_i[1] = 1'b0;
    send(1, 3, 1'b1);
    send(1, 5, 1'b1);
    valid_i[1] = 1'b0;
    #1;
    check("bp_ready", 1, {31'h0, ready_o[1]}, 32'h0);
    check("bp_data", 1, data1, 32'h8);
    tick();
    tick();
    check("bp_hold", 1, data1, 32'h8);
    ready_i[1] = 1'b1;
    tick();
    check("bp_second", 1, data1, 32'h20);
    tick();
    check("bp_empty", 1, {31'h0, valid_o[1]}, 32'h0);

    // Full slice drained and refilled in the same cycle.
    ready_i[0] = 1'b0;
    send(0, 4, 1'b1);
    check("fdn_first", 0, data0, 32'h10);
    ready_i[0] = 1'b1;
    send(0, 9, 1'b1);
    valid_i[0] = 1'b0;
    check("fdn_valid", 0, {31'h0, valid_o[0]}, 32'h1);
    check("fdn_data", 0, data0, 32'h200);
    tick();

    // Index 0 with the enable set.
    send(0, 0, 1'b1);
    valid_i[0] = 1'b0;
    check("x0_valid", 0, {31'h0, valid_o[0]}, 32'h1);
    check("x0_data", 0, data0, x0_exp);
    tick();

    // Reset while the ADDR_W=3 instance is full and stalled.
    ready_i[2] = 1'b0;
    send(2, 6, 1'b1);
    send(2, 2, 1'b1);
    check("a3_full", 2, {24'h0, data2}, 32'h40);
    addr_i[2] = 5'd1;
    rst_i = 1'b1;
    tick();
    rst_i      = 1'b0;
    valid_i[2] = 1'b0;
    check("a3_rst_valid", 2, {31'h0, valid_o[2]}, 32'h0);
    check("a3_rst_data", 2, {24'h0, data2}, 32'h0);
    ready_i[2] = 1'b1;
    tick();
    tick();
    check("a3_no_ghost", 2, {31'h0, valid_o[2]}, 32'h0);

    // Two-cycle latency after reset.
    send(2, 5, 1'b1);
    valid_i[2] = 1'b0;
    check("a3_lat1", 2, {31'h0, valid_o[2]}, 32'h0);
    tick();
    check("a3_lat2", 2, {24'h0, data2}, 32'h20);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
